// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential repeated-addition multiplier.
// Holds the controller state encoding and an absolute-value helper.
package seq_mult_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // The caller zero-extends a W-bit value and truncates the result back to W bits.
  // Negating the most negative value then yields 2^(W-1) as an unsigned magnitude.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                             input logic             is_neg);
    return is_neg ? -v : v;
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Datapath for the repeated-addition multiplier: operand register, product
// accumulator, iteration down-counter and its zero compare.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned PW = 2 * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  cnt_in,
  output logic [PW-1:0] acc,
  output logic          zero
);

  logic [W-1:0] a_q;
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      cnt_q <= '0;
      acc   <= '0;
    end else if (load) begin
      a_q   <= a_in;
      cnt_q <= cnt_in;
      acc   <= '0;
    end else if (step) begin
      acc   <= acc + PW'(a_q);
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_mult_ctrl.sv
// Self-sequencing repeated-addition multiplier with start/done handshake,
// optional signed operands and operand swap to minimise the iteration count.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter  int unsigned W       = 16,
  parameter  bit          SWAP_EN = 1'b1,
  localparam int unsigned PW      = 2 * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [W-1:0]  dataa,
  input  logic [W-1:0]  datab,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product,
  output logic          zero
);

  state_t        state_q, state_d;
  logic          load, step;
  logic          sign_a, sign_b, neg_in, neg_q;
  logic [W-1:0]  mag_a, mag_b;
  logic          swap;
  logic [W-1:0]  a_sel, cnt_sel;
  logic [PW-1:0] acc;

  assign sign_a = signed_mode & dataa[W-1];
  assign sign_b = signed_mode & datab[W-1];
  assign neg_in = sign_a ^ sign_b;
  assign mag_a  = W'(abs_w(MAX_W'(dataa), sign_a));
  assign mag_b  = W'(abs_w(MAX_W'(datab), sign_b));

  // Counting down the smaller magnitude gives the same sum in fewer cycles.
  assign swap    = SWAP_EN && (mag_b > mag_a);
  assign a_sel   = swap ? mag_b : mag_a;
  assign cnt_sel = swap ? mag_a : mag_b;

  seq_mult_dp #(
    .W  (W),
    .PW (PW)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .a_in   (a_sel),
    .cnt_in (cnt_sel),
    .acc    (acc),
    .zero   (zero)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (zero) state_d = FIX;
        else      step    = 1'b1;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == FIX);
      if (load) begin
        neg_q <= neg_in;
        busy  <= 1'b1;
      end
      if (state_q == FIX) begin
        product <= neg_q ? -acc : acc;
        busy    <= 1'b0;
      end
    end
  end

endmodule
